ring_client_port: RTL and testbench
===================================

RING_CLIENT_PORT -- requirements
Module: ring_client_port

Interface
REQ-001 Parameter DEPTH, 512, data field width in bits.
REQ-002 Parameter MY_ID, 0, 5-bit ring id of this client.
REQ-003 Parameter TIMEOUT, 1024, WAIT_RESP cycles before error completion; range 2..65535.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  1  client request present.
REQ-007 req_ready  out  1  request accepted when high with req_valid.
REQ-008 req_write  in  1  1=write, 0=read.
REQ-009 req_addr  in  36  request address.
REQ-010 req_data  in  DEPTH  write data; ignored for reads.
REQ-011 resp_valid  out  1  completion present.
REQ-012 resp_ready  in  1  client consumes completion.
REQ-013 resp_data  out  DEPTH  read data; 0 for writes and errors.
REQ-014 resp_err  out  1  completion is timeout or no-responder error.
REQ-015 ring_addr_in / ring_data_in / ring_id_in / ring_type_in  in  36/DEPTH/5/3  slot currently at the attached ring stop.
REQ-016 overwrite  out  1  replace current slot with ring_*_out.
REQ-017 ring_addr_out / ring_data_out / ring_id_out / ring_type_out  out  36/DEPTH/5/3  replacement slot.

Function
REQ-018 Packet type encoding SHALL be: 0 EMPTY, 1 READ_REQ, 2 WRITE_REQ, 3 READ_RESP, 4 WRITE_ACK; 5-7 reserved, always passed untouched.
REQ-019 States SHALL be IDLE, WAIT_SLOT, WAIT_RESP, HOLD_RESP; exactly one transaction outstanding.
REQ-020 req_ready SHALL equal (state==IDLE); on req_valid&&req_ready, latch write/addr/data and go WAIT_SLOT.
REQ-021 Injection SHALL never occur in the acceptance cycle; earliest injection is the cycle after acceptance.
REQ-022 In WAIT_SLOT, when ring_type_in==EMPTY, or a stale completion for MY_ID (REQ-026) is present, overwrite SHALL be 1 with {latched addr, latched data (0 for read), MY_ID, READ_REQ or WRITE_REQ}; next state WAIT_RESP, timeout counter cleared to 0.
REQ-023 In WAIT_SLOT with any other slot, overwrite SHALL be 0; no timeout in WAIT_SLOT.
REQ-024 In WAIT_RESP, a slot with id==MY_ID and type matching the op (READ_RESP for read, WRITE_ACK for write) SHALL be consumed: overwrite=1 with all-zero EMPTY packet; capture resp_data (ring_data_in for read, 0 for write), resp_err=0; go HOLD_RESP.
REQ-025 In WAIT_RESP, our own request returning (id==MY_ID, type READ_REQ/WRITE_REQ) SHALL be consumed as EMPTY and complete with resp_err=1, resp_data=0.
REQ-026 A READ_RESP/WRITE_ACK with id==MY_ID arriving outside WAIT_RESP, or with non-matching type, is stale: SHALL be consumed as EMPTY (or replaced per REQ-022) and discarded.
REQ-027 Timeout counter SHALL increment each WAIT_RESP cycle without completion; at count==TIMEOUT-1 complete with resp_err=1, resp_data=0.
REQ-028 Completion and timeout in the same cycle: completion SHALL win, resp_err=0.
REQ-029 overwrite and ring_*_out SHALL be combinational from state, latched request and ring_*_in; ring_*_out SHALL be 0 when overwrite=0.
REQ-030 resp_valid SHALL equal (state==HOLD_RESP); resp_data/resp_err stable while held; resp_ready in HOLD_RESP returns to IDLE; req_ready rises the next cycle.
REQ-031 Slots with id!=MY_ID SHALL never be modified except EMPTY slots under REQ-022.

Reset
REQ-032 On rst high at a clock edge, in any state including mid-transaction: state IDLE, latched request 0, counter 0, resp_data 0, resp_err 0; hence req_ready=1, resp_valid=0, overwrite=0.
REQ-033 A completion for a transaction abandoned by reset SHALL be discarded as stale per REQ-026.

Verification
REQ-034 MY_ID=3: read addr 0x100 accepted, EMPTY slot next cycle -> overwrite=1, {0x100,0,3,1}; READ_RESP id 3 data 0xAB -> slot emptied, resp_valid=1, resp_data=0xAB, resp_err=0.
REQ-035 Write pending, ring carries id 7 READ_REQ for 5 cycles then EMPTY -> overwrite=0 for 5 cycles, injection on 6th; WRITE_ACK id 3 -> resp_data=0, resp_err=0.
REQ-036 TIMEOUT=8, no response -> exactly 8 WAIT_RESP cycles then resp_valid=1, resp_err=1; late READ_RESP id 3 in IDLE -> overwrite=1 EMPTY, no resp_valid.
REQ-037 Injected READ_REQ id 3 returns unserviced -> consumed, resp_err=1; matching response on timeout cycle -> resp_err=0.
REQ-038 rst asserted in WAIT_RESP -> next cycle req_ready=1, resp_valid=0; hold resp_ready=0 for 10 cycles in HOLD_RESP -> resp_data stable, req_ready=0.

Source files
------------

// File: rtl/ring_client_port.sv
// Ring stop client: injects one request into the ring, then waits for its
// completion, a timeout, or its own unserviced request coming back around.
module ring_client_port #(
    parameter int         DEPTH   = 512,
    parameter logic [4:0] MY_ID   = 5'd0,
    parameter int         TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [35:0]      req_addr,
    input  logic [DEPTH-1:0] req_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [DEPTH-1:0] resp_data,
    output logic             resp_err,
    input  logic [35:0]      ring_addr_in,
    input  logic [DEPTH-1:0] ring_data_in,
    input  logic [4:0]       ring_id_in,
    input  logic [2:0]       ring_type_in,
    output logic             overwrite,
    output logic [35:0]      ring_addr_out,
    output logic [DEPTH-1:0] ring_data_out,
    output logic [4:0]       ring_id_out,
    output logic [2:0]       ring_type_out
);

    localparam logic [2:0] T_EMPTY = 3'd0;
    localparam logic [2:0] T_RDREQ = 3'd1;
    localparam logic [2:0] T_WRREQ = 3'd2;
    localparam logic [2:0] T_RDRSP = 3'd3;
    localparam logic [2:0] T_WRACK = 3'd4;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SLOT,
        S_WAIT_RESP,
        S_HOLD_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic             r_write;
    logic [35:0]      r_addr;
    logic [DEPTH-1:0] r_data;
    logic [15:0]      r_cnt;
    logic [DEPTH-1:0] r_resp_data;
    logic             r_resp_err;

    logic             w_mine;
    logic             w_match;
    logic             w_own_req;
    logic             w_stale;
    logic             w_tmo;
    logic             w_inject;
    logic             w_done;
    logic             w_err;
    logic [DEPTH-1:0] w_rdata;
    logic             w_accept;
    logic             w_unused;

    // Address of incoming slots never matters to this client.
    assign w_unused = ^ring_addr_in;

    assign w_mine    = (ring_id_in == MY_ID);
    assign w_match   = w_mine &&
                       (ring_type_in == (r_write ? T_WRACK : T_RDRSP));
    assign w_own_req = w_mine &&
                       (ring_type_in == T_RDREQ || ring_type_in == T_WRREQ);
    // Any of our completions that cannot finish the live transaction.
    assign w_stale   = w_mine &&
                       (ring_type_in == T_RDRSP || ring_type_in == T_WRACK) &&
                       !(r_state == S_WAIT_RESP && w_match);
    assign w_tmo     = (r_cnt == TMO_LAST);
    assign w_accept  = req_valid && req_ready;

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_HOLD_RESP);
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (req_valid)  w_next = S_WAIT_SLOT;
            S_WAIT_SLOT: if (w_inject)   w_next = S_WAIT_RESP;
            S_WAIT_RESP: if (w_done)     w_next = S_HOLD_RESP;
            S_HOLD_RESP: if (resp_ready) w_next = S_IDLE;
            default:                     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        overwrite     = 1'b0;
        ring_addr_out = '0;
        ring_data_out = '0;
        ring_id_out   = '0;
        ring_type_out = T_EMPTY;
        w_inject      = 1'b0;
        w_done        = 1'b0;
        w_err         = 1'b0;
        w_rdata       = '0;
        unique case (r_state)
            S_IDLE, S_HOLD_RESP: begin
                overwrite = w_stale;
            end
            S_WAIT_SLOT: begin
                if (ring_type_in == T_EMPTY || w_stale) begin
                    w_inject      = 1'b1;
                    overwrite     = 1'b1;
                    ring_addr_out = r_addr;
                    ring_data_out = r_write ? r_data : '0;
                    ring_id_out   = MY_ID;
                    ring_type_out = r_write ? T_WRREQ : T_RDREQ;
                end
            end
            S_WAIT_RESP: begin
                // A real completion beats a coincident timeout.
                overwrite = w_match || w_own_req || w_stale;
                w_done    = w_match || w_own_req || w_tmo;
                w_err     = !w_match && (w_own_req || w_tmo);
                if (w_match && !r_write) w_rdata = ring_data_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_cnt       <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_data  <= req_data;
            end
            if (w_inject)
                r_cnt <= '0;
            else if (r_state == S_WAIT_RESP && !w_done)
                r_cnt <= r_cnt + 16'd1;
            if (w_done) begin
                r_resp_data <= w_rdata;
                r_resp_err  <= w_err;
            end
        end
    end

endmodule

// File: tb/tb_ring_client_port.sv
// Directed bench for ring_client_port: injection, completion, timeout,
// stale responses, reset abandonment and response hold.
module tb_ring_client_port;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [35:0]   req_addr;
    logic [DW-1:0] req_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    logic [35:0]   ring_addr_in;
    logic [DW-1:0] ring_data_in;
    logic [4:0]    ring_id_in;
    logic [2:0]    ring_type_in;
    logic          overwrite;
    logic [35:0]   ring_addr_out;
    logic [DW-1:0] ring_data_out;
    logic [4:0]    ring_id_out;
    logic [2:0]    ring_type_out;

    int vecs = 0;
    int errs = 0;

    ring_client_port #(
        .DEPTH(DW),
        .MY_ID(5'd3),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_data(req_data),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data(resp_data),
        .resp_err(resp_err),
        .ring_addr_in(ring_addr_in),
        .ring_data_in(ring_data_in),
        .ring_id_in(ring_id_in),
        .ring_type_in(ring_type_in),
        .overwrite(overwrite),
        .ring_addr_out(ring_addr_out),
        .ring_data_out(ring_data_out),
        .ring_id_out(ring_id_out),
        .ring_type_out(ring_type_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic slot(input logic [35:0] a, input logic [DW-1:0] d,
                        input logic [4:0] id, input logic [2:0] t);
        ring_addr_in = a;
        ring_data_in = d;
        ring_id_in   = id;
        ring_type_in = t;
    endtask

    // Foreign, non-empty slot: must always pass untouched.
    task automatic busy();
        slot(36'h0, '0, 5'd9, 3'd1);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Accept a request, then inject it into an EMPTY slot.
    task automatic start(input logic w, input logic [35:0] a,
                         input logic [DW-1:0] d, input string tag);
        tick();
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_data  = d;
        busy();
        #1 chk({tag, "_ready"}, 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        slot(36'h0, '0, 5'd0, 3'd0);
        #1 chk({tag, "_inj"}, 64'(overwrite), 64'd1);
        chk({tag, "_injtype"}, 64'(ring_type_out), w ? 64'd2 : 64'd1);
    endtask

    task automatic release_resp(input string tag);
        tick();
        busy();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1 chk({tag, "_rv0"}, 64'(resp_valid), 64'd0);
        chk({tag, "_rdy1"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_data   = '0;
        resp_ready = 1'b0;
        busy();
        tick();
        tick();
        rst = 1'b0;
        slot(36'h0, '0, 5'd0, 3'd0);
        #1 chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_rvalid", 64'(resp_valid), 64'd0);
        chk("rst_ovw_empty", 64'(overwrite), 64'd0);

        // Basic read; acceptance cycle sees EMPTY but must not inject.
        tick();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 36'h100;
        req_data  = 32'hDEAD;
        slot(36'h0, '0, 5'd0, 3'd0);
        #1 chk("rd_acc_ovw", 64'(overwrite), 64'd0);
        chk("rd_acc_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        #1 chk("rd_inj_ovw", 64'(overwrite), 64'd1);
        chk("rd_inj_addr", 64'(ring_addr_out), 64'h100);
        chk("rd_inj_data", 64'(ring_data_out), 64'd0);
        chk("rd_inj_id", 64'(ring_id_out), 64'd3);
        chk("rd_inj_type", 64'(ring_type_out), 64'd1);
        tick();
        slot(36'h0, 32'hAB, 5'd3, 3'd3);
        #1 chk("rd_cons_ovw", 64'(overwrite), 64'd1);
        chk("rd_cons_type", 64'(ring_type_out), 64'd0);
        chk("rd_cons_data", 64'(ring_data_out), 64'd0);
        chk("rd_cons_rv", 64'(resp_valid), 64'd0);
        tick();
        busy();
        #1 chk("rd_rv", 64'(resp_valid), 64'd1);
        chk("rd_data", 64'(resp_data), 64'hAB);
        chk("rd_err", 64'(resp_err), 64'd0);
        chk("rd_busy_ovw", 64'(overwrite), 64'd0);
        release_resp("rd");

        // Write delayed 5 cycles by foreign traffic.
        tick();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 36'h200;
        req_data  = 32'h55;
        slot(36'h0, '0, 5'd7, 3'd1);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("wr_hold_ovw", 64'(overwrite), 64'd0);
            tick();
        end
        slot(36'h0, '0, 5'd0, 3'd0);
        #1 chk("wr_inj_ovw", 64'(overwrite), 64'd1);
        chk("wr_inj_type", 64'(ring_type_out), 64'd2);
        chk("wr_inj_data", 64'(ring_data_out), 64'h55);
        chk("wr_inj_addr", 64'(ring_addr_out), 64'h200);
        tick();
        slot(36'h0, 32'h77, 5'd5, 3'd3);
        #1 chk("wr_foreign_ovw", 64'(overwrite), 64'd0);
        tick();
        slot(36'h0, 32'h77, 5'd3, 3'd4);
        #1 chk("wr_ack_ovw", 64'(overwrite), 64'd1);
        tick();
        busy();
        #1 chk("wr_rv", 64'(resp_valid), 64'd1);
        chk("wr_data", 64'(resp_data), 64'd0);
        chk("wr_err", 64'(resp_err), 64'd0);
        release_resp("wr");

        // Timeout: exactly 8 WAIT_RESP cycles, then late response is stale.
        start(1'b0, 36'h300, '0, "to");
        for (int i = 0; i < 8; i++) begin
            tick();
            busy();
            #1 chk("to_wait_rv", 64'(resp_valid), 64'd0);
        end
        tick();
        #1 chk("to_rv", 64'(resp_valid), 64'd1);
        chk("to_err", 64'(resp_err), 64'd1);
        chk("to_data", 64'(resp_data), 64'd0);
        release_resp("to");
        slot(36'h0, 32'h12, 5'd3, 3'd3);
        #1 chk("late_ovw", 64'(overwrite), 64'd1);
        chk("late_type", 64'(ring_type_out), 64'd0);
        tick();
        busy();
        #1 chk("late_rv", 64'(resp_valid), 64'd0);

        // Own request returns unserviced.
        start(1'b0, 36'h400, '0, "ret");
        tick();
        slot(36'h400, '0, 5'd3, 3'd1);
        #1 chk("ret_ovw", 64'(overwrite), 64'd1);
        chk("ret_type", 64'(ring_type_out), 64'd0);
        tick();
        busy();
        #1 chk("ret_err", 64'(resp_err), 64'd1);
        chk("ret_rv", 64'(resp_valid), 64'd1);
        release_resp("ret");

        // Response lands on the timeout cycle: completion wins.
        start(1'b0, 36'h500, '0, "race");
        for (int i = 0; i < 7; i++) begin
            tick();
            busy();
        end
        tick();
        slot(36'h0, 32'h77, 5'd3, 3'd3);
        tick();
        busy();
        #1 chk("race_rv", 64'(resp_valid), 64'd1);
        chk("race_err", 64'(resp_err), 64'd0);
        chk("race_data", 64'(resp_data), 64'h77);
        release_resp("race");

        // Stale response in WAIT_SLOT is replaced by our request.
        tick();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 36'h600;
        req_data  = 32'h66;
        busy();
        tick();
        req_valid = 1'b0;
        slot(36'h0, 32'h1, 5'd3, 3'd3);
        #1 chk("stale_inj_ovw", 64'(overwrite), 64'd1);
        chk("stale_inj_type", 64'(ring_type_out), 64'd2);
        chk("stale_inj_id", 64'(ring_id_out), 64'd3);
        tick();
        slot(36'h0, '0, 5'd3, 3'd4);
        tick();
        busy();
        #1 chk("stale_wr_rv", 64'(resp_valid), 64'd1);
        release_resp("stale");

        // Reset mid-transaction, then its response is stale.
        start(1'b0, 36'h700, '0, "rstm");
        tick();
        busy();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 chk("rstm_ready", 64'(req_ready), 64'd1);
        chk("rstm_rv", 64'(resp_valid), 64'd0);
        chk("rstm_ovw", 64'(overwrite), 64'd0);
        tick();
        slot(36'h0, 32'h9, 5'd3, 3'd3);
        #1 chk("rstm_stale_ovw", 64'(overwrite), 64'd1);
        tick();
        busy();
        #1 chk("rstm_stale_rv", 64'(resp_valid), 64'd0);

        // Response held for 10 cycles without resp_ready.
        start(1'b0, 36'h800, '0, "hold");
        tick();
        slot(36'h0, 32'h99, 5'd3, 3'd3);
        for (int i = 0; i < 10; i++) begin
            tick();
            busy();
            #1 chk("hold_data", 64'(resp_data), 64'h99);
            chk("hold_rv", 64'(resp_valid), 64'd1);
            chk("hold_ready", 64'(req_ready), 64'd0);
        end
        release_resp("hold");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
